// File: rtl/bht_btb_predictor_if.sv
// Fetch-lookup, branch-resolve update and statistics signals of the predictor.
// Ports: fetch_* / upd_* flow from the pipe into the predictor;
//        pred_* / stat_* flow back out.
interface bht_btb_predictor_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  // Pipeline side: drives fetch and resolved-branch info, consumes predictions.
  modport master (
    output fetch_valid, fetch_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_target, pred_hit,
    input  stat_branches, stat_mispredicts
  );

  // Predictor side.
  modport slave (
    input  fetch_valid, fetch_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_target, pred_hit,
    output stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bht_btb_predictor.sv
// Direct-mapped 2-bit BHT + BTB branch predictor with branch/mispredict statistics.
// Latency: lookup is combinational (zero cycles); updates take effect from the next cycle.
// Backpressure: none -- every update is accepted, one per cycle.
// Ports: i_clk (rising edge), i_rst (synchronous, active-high),
//        io_bp (slave modport: fetch lookup, update, statistics).
module bht_btb_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  bht_btb_predictor_if.slave   io_bp
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 2 ** INDEX_BITS;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];
  logic [31:0]         r_stat_br;
  logic [31:0]         r_stat_mp;

  // pc[1:0] is never used: entries are word-granular.
  logic [INDEX_BITS-1:0] w_fidx, w_uidx;
  logic [TAG_BITS-1:0]   w_ftag, w_utag;
  logic                  w_fhit, w_uhit;
  logic [1:0]            w_ctr_next;

  assign w_fidx = io_bp.fetch_pc[INDEX_BITS+1:2];
  assign w_ftag = io_bp.fetch_pc[31:INDEX_BITS+2];
  assign w_uidx = io_bp.upd_pc[INDEX_BITS+1:2];
  assign w_utag = io_bp.upd_pc[31:INDEX_BITS+2];

  // Lookup reads table state only, so a same-cycle update is not bypassed.
  assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

  assign io_bp.pred_hit    = io_bp.fetch_valid && w_fhit;
  assign io_bp.pred_taken  = io_bp.pred_hit && r_ctr[w_fidx][1];
  assign io_bp.pred_target = io_bp.pred_taken ? r_target[w_fidx] : io_bp.fetch_pc + 32'd4;

  assign io_bp.stat_branches    = r_stat_br;
  assign io_bp.stat_mispredicts = r_stat_mp;

  // Saturating counter step on a hit; a fresh allocation starts weakly taken.
  always_comb begin
    w_ctr_next = 2'b10;
    if (w_uhit) begin
      if (io_bp.upd_taken)
        w_ctr_next = (r_ctr[w_uidx] == 2'b11) ? 2'b11 : r_ctr[w_uidx] + 2'd1;
      else
        w_ctr_next = (r_ctr[w_uidx] == 2'b00) ? 2'b00 : r_ctr[w_uidx] - 2'd1;
    end
  end

  // Valid bits, counters and statistics: reset clears all learned state at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
      r_stat_br <= 32'd0;
      r_stat_mp <= 32'd0;
    end else if (io_bp.upd_valid) begin
      // A not-taken miss leaves the entry alone rather than evicting it.
      if (w_uhit || io_bp.upd_taken) begin
        r_valid[w_uidx] <= 1'b1;
        r_ctr[w_uidx]   <= w_ctr_next;
      end
      r_stat_br <= r_stat_br + 32'd1;
      r_stat_mp <= r_stat_mp + {31'd0, io_bp.upd_mispredict};
    end
  end

  // Tag and target carry no reset; they are only observed behind a valid bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst && io_bp.upd_valid && io_bp.upd_taken) begin
      r_tag[w_uidx]    <= w_utag;
      r_target[w_uidx] <= io_bp.upd_target;
    end
  end
endmodule

// File: tb/tb_bht_btb_predictor.sv
module tb_bht_btb_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  bht_btb_predictor_if bp ();

  bht_btb_predictor #(.INDEX_BITS(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bp (bp.slave)
  );

  always #5 clk = ~clk;

  // Drive a lookup and let the combinational outputs settle.
  task automatic look(input logic [31:0] pc, input logic v);
    bp.fetch_pc    = pc;
    bp.fetch_valid = v;
    #1;
  endtask

  // Apply one update at the next rising edge.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
    bp.upd_valid      = 1'b1;
    bp.upd_pc         = pc;
    bp.upd_taken      = tk;
    bp.upd_target     = tgt;
    bp.upd_mispredict = mp;
    @(posedge clk); #1;
    bp.upd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    look(32'h100, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b want 0", bp.pred_hit); end
    n_tests++; if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %b want 0", bp.pred_taken); end
    n_tests++; if (bp.pred_target !== 32'h104) begin n_fail++; $display("FAIL rst_target: got %h want 00000104", bp.pred_target); end
    n_tests++; if (bp.stat_branches !== 32'd0) begin n_fail++; $display("FAIL rst_stat_br: got %0d want 0", bp.stat_branches); end
    n_tests++; if (bp.stat_mispredicts !== 32'd0) begin n_fail++; $display("FAIL rst_stat_mp: got %0d want 0", bp.stat_mispredicts); end
  endtask

  task automatic test_allocate;
    upd(32'h100, 1'b1, 32'h80, 1'b1);
    look(32'h100, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b1) begin n_fail++; $display("FAIL alloc_hit: got %b want 1", bp.pred_hit); end
    n_tests++; if (bp.pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_taken: got %b want 1", bp.pred_taken); end
    n_tests++; if (bp.pred_target !== 32'h80) begin n_fail++; $display("FAIL alloc_target: got %h want 00000080", bp.pred_target); end
    n_tests++; if (bp.stat_branches !== 32'd1) begin n_fail++; $display("FAIL alloc_stat_br: got %0d want 1", bp.stat_branches); end
    n_tests++; if (bp.stat_mispredicts !== 32'd1) begin n_fail++; $display("FAIL alloc_stat_mp: got %0d want 1", bp.stat_mispredicts); end
    look(32'h100, 1'b0);
    n_tests++; if (bp.pred_hit !== 1'b0) begin n_fail++; $display("FAIL novalid_hit: got %b want 0", bp.pred_hit); end
    n_tests++; if (bp.pred_target !== 32'h104) begin n_fail++; $display("FAIL novalid_target: got %h want 00000104", bp.pred_target); end
  endtask

  task automatic test_counter;
    // ctr 10 -> 01 -> 00
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b1);
    n_tests++; if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL ctr01_taken: got %b want 0", bp.pred_taken); end
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b1) begin n_fail++; $display("FAIL ctr00_hit: got %b want 1", bp.pred_hit); end
    n_tests++; if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL ctr00_taken: got %b want 0", bp.pred_taken); end
    n_tests++; if (bp.pred_target !== 32'h104) begin n_fail++; $display("FAIL ctr00_target: got %h want 00000104", bp.pred_target); end
    // 00 -> 01 -> 10 -> 11, fourth taken saturates at 11 and retargets to 0x90
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    look(32'h100, 1'b1);
    n_tests++; if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL ctr_up01_taken: got %b want 0", bp.pred_taken); end
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    upd(32'h100, 1'b1, 32'h90, 1'b0);
    look(32'h100, 1'b1);
    n_tests++; if (bp.pred_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_sat_taken: got %b want 1", bp.pred_taken); end
    n_tests++; if (bp.pred_target !== 32'h90) begin n_fail++; $display("FAIL ctr_retarget: got %h want 00000090", bp.pred_target); end
    // 11 -> 10 still taken, target kept by not-taken update; 10 -> 01 not taken
    upd(32'h100, 1'b0, 32'hDEAD0, 1'b0);
    look(32'h100, 1'b1);
    n_tests++; if (bp.pred_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_11to10_taken: got %b want 1", bp.pred_taken); end
    n_tests++; if (bp.pred_target !== 32'h90) begin n_fail++; $display("FAIL ctr_nt_keeps_target: got %h want 00000090", bp.pred_target); end
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b1);
    n_tests++; if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL ctr_10to01_taken: got %b want 0", bp.pred_taken); end
    n_tests++; if (bp.stat_branches !== 32'd9) begin n_fail++; $display("FAIL ctr_stat_br: got %0d want 9", bp.stat_branches); end
    n_tests++; if (bp.stat_mispredicts !== 32'd1) begin n_fail++; $display("FAIL ctr_stat_mp: got %0d want 1", bp.stat_mispredicts); end
  endtask

  task automatic test_alias;
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    upd(32'h200, 1'b1, 32'h40, 1'b1);
    look(32'h100, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b0) begin n_fail++; $display("FAIL alias_old_hit: got %b want 0", bp.pred_hit); end
    n_tests++; if (bp.pred_target !== 32'h104) begin n_fail++; $display("FAIL alias_old_target: got %h want 00000104", bp.pred_target); end
    look(32'h200, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b1) begin n_fail++; $display("FAIL alias_new_hit: got %b want 1", bp.pred_hit); end
    n_tests++; if (bp.pred_target !== 32'h40) begin n_fail++; $display("FAIL alias_new_target: got %h want 00000040", bp.pred_target); end
    upd(32'h300, 1'b0, 32'h999, 1'b1);
    look(32'h200, 1'b1);
    n_tests++; if (bp.pred_target !== 32'h40) begin n_fail++; $display("FAIL ntmiss_keep_target: got %h want 00000040", bp.pred_target); end
    look(32'h300, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b0) begin n_fail++; $display("FAIL ntmiss_no_alloc: got %b want 0", bp.pred_hit); end
    n_tests++; if (bp.pred_target !== 32'h304) begin n_fail++; $display("FAIL ntmiss_target: got %h want 00000304", bp.pred_target); end
    n_tests++; if (bp.stat_branches !== 32'd12) begin n_fail++; $display("FAIL alias_stat_br: got %0d want 12", bp.stat_branches); end
    n_tests++; if (bp.stat_mispredicts !== 32'd3) begin n_fail++; $display("FAIL alias_stat_mp: got %0d want 3", bp.stat_mispredicts); end
  endtask

  task automatic test_same_cycle;
    bp.upd_valid      = 1'b1;
    bp.upd_pc         = 32'h1004;
    bp.upd_taken      = 1'b1;
    bp.upd_target     = 32'h2000;
    bp.upd_mispredict = 1'b0;
    look(32'h1004, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b0) begin n_fail++; $display("FAIL same_cyc_hit: got %b want 0", bp.pred_hit); end
    n_tests++; if (bp.pred_target !== 32'h1008) begin n_fail++; $display("FAIL same_cyc_target: got %h want 00001008", bp.pred_target); end
    @(posedge clk); #1;
    bp.upd_valid = 1'b0;
    look(32'h1004, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b1) begin n_fail++; $display("FAIL next_cyc_hit: got %b want 1", bp.pred_hit); end
    n_tests++; if (bp.pred_taken !== 1'b1) begin n_fail++; $display("FAIL next_cyc_taken: got %b want 1", bp.pred_taken); end
    look(32'h1007, 1'b1);
    n_tests++; if (bp.pred_target !== 32'h2000) begin n_fail++; $display("FAIL lowbits_ignored: got %h want 00002000", bp.pred_target); end
    n_tests++; if (bp.stat_branches !== 32'd13) begin n_fail++; $display("FAIL same_stat_br: got %0d want 13", bp.stat_branches); end
  endtask

  task automatic test_reset_mid;
    bp.upd_valid      = 1'b1;
    bp.upd_pc         = 32'h1004;
    bp.upd_taken      = 1'b1;
    bp.upd_target     = 32'h3000;
    bp.upd_mispredict = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bp.upd_valid = 1'b0;
    look(32'h1004, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b0) begin n_fail++; $display("FAIL rstmid_hit_1004: got %b want 0", bp.pred_hit); end
    look(32'h200, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b0) begin n_fail++; $display("FAIL rstmid_hit_200: got %b want 0", bp.pred_hit); end
    n_tests++; if (bp.pred_target !== 32'h204) begin n_fail++; $display("FAIL rstmid_target_200: got %h want 00000204", bp.pred_target); end
    n_tests++; if (bp.stat_branches !== 32'd0) begin n_fail++; $display("FAIL rstmid_stat_br: got %0d want 0", bp.stat_branches); end
    n_tests++; if (bp.stat_mispredicts !== 32'd0) begin n_fail++; $display("FAIL rstmid_stat_mp: got %0d want 0", bp.stat_mispredicts); end
    look(32'hFFFFFFFC, 1'b1);
    n_tests++; if (bp.pred_hit !== 1'b0) begin n_fail++; $display("FAIL wrap_hit: got %b want 0", bp.pred_hit); end
    n_tests++; if (bp.pred_target !== 32'h0) begin n_fail++; $display("FAIL wrap_target: got %h want 00000000", bp.pred_target); end
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    n_tests++; if (bp.stat_branches !== 32'd1) begin n_fail++; $display("FAIL post_rst_stat_br: got %0d want 1", bp.stat_branches); end
    n_tests++; if (bp.stat_mispredicts !== 32'd1) begin n_fail++; $display("FAIL post_rst_stat_mp: got %0d want 1", bp.stat_mispredicts); end
  endtask

  initial begin
    bp.fetch_valid    = 1'b0;
    bp.fetch_pc       = 32'h0;
    bp.upd_valid      = 1'b0;
    bp.upd_pc         = 32'h0;
    bp.upd_taken      = 1'b0;
    bp.upd_target     = 32'h0;
    bp.upd_mispredict = 1'b0;
    test_reset;
    test_allocate;
    test_counter;
    test_alias;
    test_same_cycle;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bht_btb_predictor.md
Name: bht_btb_predictor

Overview:
Direct-mapped branch predictor (2-bit BHT + BTB) upstream of the execute branch unit. Combinationally supplies pred_taken/pred_target for each fetched PC; these travel down the pipe and are checked by the branch unit. Resolved outcomes (actual_taken, actual_target, mispredict) return on the update port and train the tables at the clock edge. Also keeps branch and mispredict statistics counters.

Parameters:
INDEX_BITS, 6, table index width; entries = 2**INDEX_BITS (64)
TAG_BITS, 30-INDEX_BITS (derived, localparam), tag = pc[31:INDEX_BITS+2]

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
fetch_valid  input  1  fetch_pc is a real lookup
fetch_pc  input  32  PC being fetched
pred_taken  output  1  predicted taken
pred_target  output  32  predicted next PC
pred_hit  output  1  BTB tag hit for fetch_pc
upd_valid  input  1  a conditional branch resolved this cycle
upd_pc  input  32  resolved branch PC (br_pc)
upd_taken  input  1  actual_taken from branch unit
upd_target  input  32  actual_target from branch unit
upd_mispredict  input  1  mispredict from branch unit
stat_branches  output  32  count of accepted updates
stat_mispredicts  output  32  count of accepted updates with upd_mispredict=1

Behaviour:
- Per entry state: valid (1), tag (TAG_BITS), target (32), ctr (2-bit saturating: 00 SNT, 01 WNT, 10 WT, 11 ST).
- idx = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]; pc[1:0] ignored everywhere.
- Lookup (combinational, zero latency): hit = valid[idx] && tag[idx]==fetch tag.
  - pred_hit = fetch_valid && hit.
  - pred_taken = pred_hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : fetch_pc+4 (32-bit wrap; 0xFFFFFFFC -> 0x00000000).
  - fetch_valid=0: pred_hit=0, pred_taken=0, pred_target=fetch_pc+4.
- Update (at rising clk when upd_valid=1 and rst=0), on entry upd idx:
  - Hit: ctr <= taken ? min(ctr+1,3) : max(ctr-1,0); if taken, target <= upd_target; not-taken leaves target.
  - Miss, taken: allocate/replace: valid<=1, tag<=upd tag, target<=upd_target, ctr<=10.
  - Miss, not taken: no table change.
  - stat_branches += 1; stat_mispredicts += upd_mispredict. Both wrap modulo 2**32.
- Lookup and update in same cycle to same idx: lookup returns pre-update contents (no bypass); update visible from the next cycle.
- Reset (synchronous, overrides upd_valid): all valid <= 0, all ctr <= 01, stat_branches <= 0, stat_mispredicts <= 0; tag/target need not be reset. With fetch_valid=0 after reset: pred_taken=0, pred_hit=0, pred_target=fetch_pc+4. Reset mid-training discards all learned state in one cycle.
- Only one update per cycle; no backpressure; no handshake (update always accepted).
- No X on outputs after reset for any fetch_pc.

Test Plan:
- Reset then lookup fetch_pc=0x100, fetch_valid=1 -> pred_hit=0, pred_taken=0, pred_target=0x104; stats = 0.
- Update upd_pc=0x100, taken=1, target=0x80, mispredict=1; next cycle lookup 0x100 -> pred_hit=1, pred_taken=1 (ctr=10), pred_target=0x80; stat_branches=1, stat_mispredicts=1.
- Two not-taken updates at 0x100 (ctr 10->01->00) -> lookup pred_hit=1, pred_taken=0, pred_target=0x104; then three taken -> ctr 11, stays 11 on a fourth taken (saturation).
- Alias: train 0x100 taken, then update 0x200 (same idx for INDEX_BITS=6) taken target 0x40 -> lookup 0x100 misses (pred_hit=0, target 0x104), lookup 0x200 hits target 0x40; not-taken miss at 0x300 leaves entry unchanged.
- Same-cycle: lookup 0x100 and first-time taken update 0x100 in one cycle -> that cycle pred_hit=0; following cycle pred_hit=1, pred_taken=1.
- Assert rst together with upd_valid=1 after training -> no update applied, all lookups miss, stats 0; fetch_pc=0xFFFFFFFC miss -> pred_target=0x00000000.
